// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider for the CPU `div` instruction.
// The divide runs on operand magnitudes, one quotient bit per cycle, and the
// signs are applied in a final fix-up cycle. The quotient truncates toward
// zero and the remainder takes the sign of the dividend.
// Optional feature macro DIV_UNSIGNED_EN adds the DivU port for `divu`.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             DivCtrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef DIV_UNSIGNED_EN
    input  logic             DivU,
`endif
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             DivStop,
    output logic             DivZero,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    // Control state
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             qsign_q, qsign_d;
    logic             rsign_q, rsign_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             stop_q, stop_d;
    logic             zero_q, zero_d;

    // Datapath state: dividend shifts out as quotient bits shift in
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    logic signed [WIDTH-1:0] a_s, b_s;
    logic                    is_unsigned;
    logic        [WIDTH:0]   shifted;
    logic signed [WIDTH:0]   trial;

    assign a_s = A;
    assign b_s = B;

`ifdef DIV_UNSIGNED_EN
    assign is_unsigned = DivU;
`else
    assign is_unsigned = 1'b0;
`endif

    // Magnitude of a two's complement value; the most negative value maps to
    // its own bit pattern, which is correct when read as unsigned.
    function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    // Two's complement negate when requested, truncated to WIDTH.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x,
                                                  input logic neg);
        return neg ? -x : x;
    endfunction

    // Next-state, datapath step and output computation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        stop_d  = 1'b0;
        zero_d  = 1'b0;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;

        // rem < divisor always holds, so the shifted value is below twice the
        // divisor and a WIDTH+1 bit signed trial cannot overflow.
        shifted = {rem_q, dvd_q[WIDTH-1]};
        trial   = shifted - {1'b0, dsr_q};

        case (state_q)
            S_IDLE: begin
                if (DivCtrl) begin
                    if (B == '0) begin
                        zero_d = 1'b1;
                    end else begin
                        dvd_d   = is_unsigned ? A : abs_val(a_s);
                        dsr_d   = is_unsigned ? B : abs_val(b_s);
                        qsign_d = ~is_unsigned & (A[WIDTH-1] ^ B[WIDTH-1]);
                        rsign_d = ~is_unsigned & A[WIDTH-1];
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                lo_d    = cond_neg(dvd_q, qsign_q);
                hi_d    = cond_neg(rem_q, rsign_q);
                stop_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and result registers, cleared by the asynchronous reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            stop_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            stop_q  <= stop_d;
            zero_q  <= zero_d;
        end
    end

    // Working registers; always reloaded on start, so no reset is needed
    always_ff @(posedge clk) begin
        dvd_q <= dvd_d;
        dsr_q <= dsr_d;
        rem_q <= rem_d;
    end

    assign HI      = hi_q;
    assign LO      = lo_q;
    assign DivStop = stop_q;
    assign DivZero = zero_q;
    assign busy    = (state_q != S_IDLE);

endmodule
